// File: rtl/hard_mem_1rw_byte_mask_d512_w64_arb_pkg.sv
// Shared types and width helpers for the byte-masked 1rw SRAM scheduler.
//   state_e     : scheduler phase (zero-fill, then serving requests)
//   mask_width  : byte-mask width for a given data width
//   idx_width   : width of a requester index, at least one bit
package hard_mem_arb_pkg;

    localparam int bits_per_byte_lp = 8;

    typedef enum logic {
        e_init  = 1'b0,
        e_ready = 1'b1
    } state_e;

    function automatic int mask_width(input int width);
        return width / bits_per_byte_lp;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hard_mem_1rw_byte_mask_d512_w64_arb_if.sv
// Requester-side bus of the scheduler: flattened per-requester request
// fields, one-hot ready, and registered read-response slots.
//   master : client side (drives requests and yumi)
//   slave  : scheduler side (drives ready and responses)
interface hard_mem_1rw_byte_mask_d512_w64_arb_if #(
    parameter int num_req_p = 2,
    parameter int width_p   = 64,
    parameter int els_p     = 512
);
    import hard_mem_arb_pkg::*;

    localparam int addr_w = $clog2(els_p);
    localparam int mask_w = mask_width(width_p);

    logic [num_req_p-1:0]         req_v_i;
    logic [num_req_p-1:0]         req_w_i;
    logic [num_req_p*addr_w-1:0]  req_addr_i;
    logic [num_req_p*width_p-1:0] req_data_i;
    logic [num_req_p*mask_w-1:0]  req_mask_i;
    logic [num_req_p-1:0]         req_ready_o;
    logic [num_req_p-1:0]         resp_v_o;
    logic [num_req_p*width_p-1:0] resp_data_o;
    logic [num_req_p-1:0]         resp_yumi_i;

    modport master (
        output req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i, resp_yumi_i,
        input  req_ready_o, resp_v_o, resp_data_o
    );

    modport slave (
        input  req_v_i, req_w_i, req_addr_i, req_data_i, req_mask_i, resp_yumi_i,
        output req_ready_o, resp_v_o, resp_data_o
    );

endinterface

// File: rtl/hard_mem_1rw_byte_mask_d512_w64_arb_rr_arb.sv
// Round-robin grant for the shared SRAM port.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_elig         : per-requester eligibility this cycle
//   o_grant        : one-hot grant (zero when nothing is eligible)
//   o_grant_idx    : index of the granted requester
// The pointer names the highest-priority requester and moves to just past
// the winner on every grant.
module hard_mem_rr_arb
    import hard_mem_arb_pkg::*;
#(
    parameter int   num_req_p = 2,
    localparam int  id_w      = idx_width(num_req_p)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [num_req_p-1:0] i_elig,
    output logic [num_req_p-1:0] o_grant,
    output logic [id_w-1:0]      o_grant_idx
);

    logic [id_w-1:0] r_ptr;
    logic [id_w-1:0] w_cand;
    logic            w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 0; k < num_req_p; k++) begin
            w_cand = id_w'((int'(r_ptr) + k) % num_req_p);
            if (!w_found && i_elig[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (o_grant_idx == id_w'(num_req_p - 1)) ? '0 : o_grant_idx + id_w'(1);
        end
    end

endmodule

// File: rtl/hard_mem_1rw_byte_mask_d512_w64_arb.sv
// Shares one 1rw byte-masked SRAM wrapper among num_req_p requesters.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_if         : requester bus (slave side)
//   mem_*_o        : access issued to the wrapper this cycle
//   mem_data_i     : wrapper read data, valid the cycle after a read issue
//   init_done_o    : high once the array has been zero-filled
//
// state   | meaning
// --------+-------------------------------------------------------------
// e_init  | writing zero to every entry, one per cycle; requests blocked
// e_ready | round-robin service, at most one access per cycle
module hard_mem_1rw_byte_mask_d512_w64_arb
    import hard_mem_arb_pkg::*;
#(
    parameter int  width_p       = 64,
    parameter int  els_p         = 512,
    parameter int  num_req_p     = 2,
    parameter bit  init_zero_p   = 1'b1,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = mask_width(width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    hard_mem_1rw_byte_mask_d512_w64_arb_if.slave req_if,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [mask_width_lp-1:0] mem_mask_o,
    input  logic [width_p-1:0]       mem_data_i,
    output logic                     init_done_o
);

    localparam int id_w = idx_width(num_req_p);
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   r_state;
    logic [addr_width_lp-1:0] r_init_cnt;
    logic                     r_rd_pend;
    logic [id_w-1:0]          r_rd_id;
    logic [num_req_p-1:0]     r_resp_v;
    logic [width_p-1:0]       r_resp_data [num_req_p];
    logic                     r_init_done;

    logic [num_req_p-1:0]     w_busy;
    logic [num_req_p-1:0]     w_elig;
    logic [num_req_p-1:0]     w_grant;
    logic [id_w-1:0]          w_gidx;
    logic                     w_gnt_any;
    logic                     w_gnt_w;

    // A requester with a read in flight or an unconsumed response may not
    // issue another read; its writes are still accepted.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_busy[i] = r_resp_v[i] | (r_rd_pend & (r_rd_id == id_w'(i)));
        end
    end

    assign w_elig = (r_state == e_ready && !reset_i)
                  ? (req_if.req_v_i & (req_if.req_w_i | ~w_busy)) : '0;

    hard_mem_rr_arb #(.num_req_p(num_req_p)) u_rr_arb (
        .i_clk       (clk_i),
        .i_reset     (reset_i),
        .i_elig      (w_elig),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    assign w_gnt_any          = |w_grant;
    assign w_gnt_w            = req_if.req_w_i[w_gidx];
    assign req_if.req_ready_o = w_grant;
    assign req_if.resp_v_o    = r_resp_v;
    assign init_done_o        = r_init_done;

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_resp
        assign req_if.resp_data_o[gi*width_p +: width_p] = r_resp_data[gi];
    end

    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_mask_o = '0;
        if (!reset_i && r_state == e_init) begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = r_init_cnt;
            mem_mask_o = '1;
        end else if (w_gnt_any) begin
            mem_v_o    = 1'b1;
            mem_w_o    = w_gnt_w;
            mem_addr_o = req_if.req_addr_i[w_gidx*addr_width_lp +: addr_width_lp];
            mem_data_o = req_if.req_data_i[w_gidx*width_p +: width_p];
            mem_mask_o = req_if.req_mask_i[w_gidx*mask_width_lp +: mask_width_lp];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= init_zero_p ? e_init : e_ready;
            r_init_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_id     <= '0;
            r_resp_v    <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == e_init) begin
                r_init_cnt <= r_init_cnt + addr_width_lp'(1);
                if (r_init_cnt == last_addr_lp) begin
                    r_state <= e_ready;
                end
            end
            r_init_done <= (r_state == e_ready) ||
                           (r_state == e_init && r_init_cnt == last_addr_lp);
            r_rd_pend <= w_gnt_any & ~w_gnt_w;
            if (w_gnt_any && !w_gnt_w) begin
                r_rd_id <= w_gidx;
            end
            // Capture and yumi never hit the same slot: a slot with a
            // pending read cannot be holding a response.
            for (int i = 0; i < num_req_p; i++) begin
                if (r_rd_pend && r_rd_id == id_w'(i)) begin
                    r_resp_v[i] <= 1'b1;
                end else if (req_if.resp_yumi_i[i]) begin
                    r_resp_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_req_p; i++) begin
            if (!reset_i && r_rd_pend && r_rd_id == id_w'(i)) begin
                r_resp_data[i] <= mem_data_i;
            end
        end
    end

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        (req_if.resp_yumi_i & ~r_resp_v) == '0);

endmodule

// File: tb/tb_hard_mem_1rw_byte_mask_d512_w64_arb.sv
// Randomized bench for the shared-SRAM scheduler. A transaction-level
// reference (flat memory array, per-requester outstanding-read record,
// round-robin winner search) predicts ready, mem_* and responses; a small
// behavioural SRAM answers the DUT's memory port.
module tb_hard_mem_1rw_byte_mask_d512_w64_arb;

    localparam int N   = 2;
    localparam int W   = 64;
    localparam int ELS = 512;
    localparam int AW  = 9;
    localparam int MW  = 8;

    logic          clk_i;
    logic          reset_i;
    logic          mem_v_o;
    logic          mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o;
    logic [MW-1:0] mem_mask_o;
    logic [W-1:0]  mem_data_i;
    logic          init_done_o;

    hard_mem_1rw_byte_mask_d512_w64_arb_if #(.num_req_p(N), .width_p(W), .els_p(ELS)) req_if ();

    hard_mem_1rw_byte_mask_d512_w64_arb #(
        .width_p(W), .els_p(ELS), .num_req_p(N), .init_zero_p(1'b1)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_if      (req_if),
        .mem_v_o     (mem_v_o),
        .mem_w_o     (mem_w_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_mask_o  (mem_mask_o),
        .mem_data_i  (mem_data_i),
        .init_done_o (init_done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // behavioural SRAM wrapper
    logic [W-1:0] sram [ELS];
    logic [W-1:0] sram_q;
    assign mem_data_i = sram_q;

    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++) begin
                    if (mem_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
                end
            end else begin
                sram_q <= sram[mem_addr_o];
            end
        end
    end

    // reference model
    logic [W-1:0] m_mem [ELS];
    logic [N-1:0] m_out;
    int           m_due [N];
    logic [W-1:0] m_exp [N];
    int           m_last;

    // stimulus
    logic [N-1:0]  s_v, s_w, s_yumi_en;
    logic [AW-1:0] s_addr [N];
    logic [W-1:0]  s_data [N];
    logic [MW-1:0] s_mask [N];

    int cyc;
    int n_checks;
    int n_fail;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs(input logic [N-1:0] yumi);
        req_if.req_v_i     = s_v;
        req_if.req_w_i     = s_w;
        req_if.resp_yumi_i = yumi;
        for (int i = 0; i < N; i++) begin
            req_if.req_addr_i[i*AW +: AW] = s_addr[i];
            req_if.req_data_i[i*W +: W]   = s_data[i];
            req_if.req_mask_i[i*MW +: MW] = s_mask[i];
        end
    endtask

    task automatic set_idle();
        s_v       = '0;
        s_w       = '0;
        s_yumi_en = '1;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0;
            s_data[i] = '0;
            s_mask[i] = '0;
        end
    endtask

    task automatic put_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input logic [MW-1:0] m);
        s_v[i]    = 1'b1;
        s_w[i]    = w;
        s_addr[i] = a;
        s_data[i] = d;
        s_mask[i] = m;
    endtask

    task automatic rand_stim(input int max_addr);
        for (int i = 0; i < N; i++) begin
            s_v[i]       = ($urandom_range(0, 3) != 0);
            s_w[i]       = $urandom_range(0, 1) == 1;
            s_addr[i]    = AW'($urandom_range(0, max_addr));
            s_data[i]    = {$urandom, $urandom};
            s_mask[i]    = MW'($urandom);
            s_yumi_en[i] = $urandom_range(0, 1) == 1;
        end
    endtask

    // one READY-phase cycle: drive, predict, compare, update model
    task automatic run_cycle();
        logic [N-1:0] exp_rv, exp_rdy, yumi;
        int g, idx;
        for (int i = 0; i < N; i++) exp_rv[i] = m_out[i] && (cyc >= m_due[i]);
        yumi = exp_rv & s_yumi_en;
        drive_inputs(yumi);
        @(negedge clk_i);
        exp_rdy = '0;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (g < 0 && s_v[idx] && (s_w[idx] || !m_out[idx])) g = idx;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("req_ready", req_if.req_ready_o, exp_rdy);
        check_val("mem_v", mem_v_o, g >= 0);
        if (g >= 0) begin
            check_val("mem_w", mem_w_o, s_w[g]);
            check_val("mem_addr", mem_addr_o, s_addr[g]);
            check_val("mem_data", mem_data_o, s_data[g]);
            check_val("mem_mask", mem_mask_o, s_mask[g]);
            m_last = g;
            if (s_w[g]) begin
                for (int b = 0; b < MW; b++)
                    if (s_mask[g][b]) m_mem[s_addr[g]][8*b +: 8] = s_data[g][8*b +: 8];
            end else begin
                m_out[g] = 1'b1;
                m_due[g] = cyc + 2;
                m_exp[g] = m_mem[s_addr[g]];
            end
        end else begin
            check_val("mem_idle", {mem_w_o, mem_addr_o, mem_data_o, mem_mask_o}, '0);
        end
        for (int i = 0; i < N; i++) begin
            check_val("resp_v", req_if.resp_v_o[i], exp_rv[i]);
            if (exp_rv[i]) check_val("resp_data", req_if.resp_data_o[i*W +: W], m_exp[i]);
        end
        for (int i = 0; i < N; i++) if (yumi[i]) m_out[i] = 1'b0;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            rand_stim(ELS - 1);
            drive_inputs('0);
            @(negedge clk_i);
            check_val("rst_ready", req_if.req_ready_o, '0);
            check_val("rst_mem", {mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o}, '0);
            if (k >= 1) begin
                check_val("rst_resp_v", req_if.resp_v_o, '0);
                check_val("rst_init_done", init_done_o, 1'b0);
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        reset_i = 1'b0;
        m_out   = '0;
    endtask

    task automatic init_phase();
        for (int c = 0; c < ELS; c++) begin
            rand_stim(ELS - 1);
            drive_inputs('0);
            @(negedge clk_i);
            check_val("init_mem", {mem_v_o, mem_w_o, mem_mask_o, mem_addr_o},
                      {1'b1, 1'b1, 8'hFF, AW'(c)});
            check_val("init_data", mem_data_o, '0);
            check_val("init_blocked", {req_if.req_ready_o, init_done_o}, '0);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check_val("init_done_rise", init_done_o, 1'b1);
        for (int a = 0; a < ELS; a++) m_mem[a] = '0;
        m_last = N - 1;
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_out    = '0;
        m_last   = N - 1;
        for (int a = 0; a < ELS; a++) sram[a] = {$urandom, $urandom};
        sram_q  = '0;
        reset_i = 1'b1;
        set_idle();
        drive_inputs('0);
        @(posedge clk_i);
        #1;

        do_reset(3);
        init_phase();

        // read the last entry after zero-fill
        put_req(0, 1'b0, AW'(511), '0, '0);
        run_cycle();
        set_idle();
        run_cycle();
        check_val("t1_resp_v", req_if.resp_v_o[0], 1'b1);
        check_val("t1_data", req_if.resp_data_o[63:0], 64'h0);
        repeat (2) run_cycle();

        // full write then read-back at T+2
        put_req(0, 1'b1, AW'(5), 64'h0123456789ABCDEF, 8'hFF);
        run_cycle();
        set_idle();
        put_req(0, 1'b0, AW'(5), '0, '0);
        run_cycle();
        set_idle();
        run_cycle();
        check_val("t2_resp_v", req_if.resp_v_o[0], 1'b1);
        check_val("t2_data", req_if.resp_data_o[63:0], 64'h0123456789ABCDEF);
        repeat (2) run_cycle();

        // low-half masked write
        put_req(0, 1'b1, AW'(5), 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        run_cycle();
        set_idle();
        put_req(0, 1'b0, AW'(5), '0, '0);
        run_cycle();
        set_idle();
        run_cycle();
        check_val("t3_data", req_if.resp_data_o[63:0], 64'h01234567FFFFFFFF);
        repeat (2) run_cycle();

        // both requesters stream writes
        for (int k = 0; k < 8; k++) begin
            put_req(0, 1'b1, AW'($urandom_range(0, 15)), {$urandom, $urandom}, MW'($urandom));
            put_req(1, 1'b1, AW'($urandom_range(0, 15)), {$urandom, $urandom}, MW'($urandom));
            run_cycle();
        end
        set_idle();

        // held response blocks req0 reads while req1 keeps being served
        put_req(0, 1'b0, AW'(5), '0, '0);
        s_yumi_en = 2'b10;
        run_cycle();
        for (int k = 0; k < 6; k++) begin
            put_req(0, 1'b0, AW'(5), '0, '0);
            put_req(1, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
                    {$urandom, $urandom}, MW'($urandom));
            s_yumi_en = 2'b10;
            run_cycle();
        end
        set_idle();
        put_req(0, 1'b0, AW'(5), '0, '0);
        run_cycle();
        put_req(0, 1'b0, AW'(6), '0, '0);
        run_cycle();
        set_idle();
        repeat (3) run_cycle();

        // reset in the cycle after a read issue
        put_req(0, 1'b1, AW'(9), 64'hDEADBEEFCAFEF00D, 8'hFF);
        run_cycle();
        set_idle();
        put_req(0, 1'b0, AW'(9), '0, '0);
        run_cycle();
        do_reset(3);
        init_phase();
        put_req(1, 1'b0, AW'(9), '0, '0);
        run_cycle();
        set_idle();
        run_cycle();
        check_val("t6_rezero", req_if.resp_data_o[127:64], 64'h0);
        repeat (2) run_cycle();

        // random traffic on a small address window
        for (int k = 0; k < 3000; k++) begin
            rand_stim(15);
            run_cycle();
        end
        set_idle();
        repeat (4) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
